// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port (WINC/WDATA/WFULL) among NREQ requesters.
// Define FIFO_ARB_BURST_EN to let one owner keep the port for up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    WCLK,
    input  logic                    WRST_n,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*DSIZE-1:0]   DATA,
    input  logic                    WFULL,
    output logic [NREQ-1:0]         GNT,
    output logic                    WINC,
    output logic [DSIZE-1:0]        WDATA,
    output logic [$clog2(NREQ)-1:0] OWNER
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fifo_wr_arbiter: NREQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("fifo_wr_arbiter: MAX_BURST must be 1..15");
    end

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] cand;
    logic [PW-1:0] winner;
    logic          rr_found;
    logic          found;
    logic          write;
    int unsigned   scan;

    function automatic logic [PW-1:0] inc_idx(input logic [PW-1:0] idx);
        return (32'(idx) == 32'(NREQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    // Scan from ptr upward, wrapping at NREQ-1 (NREQ need not be a power of two).
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan     = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = (32'(ptr) + k) % 32'(NREQ);
            cand = PW'(scan);
            if (!rr_found && REQ[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign write = found && !WFULL;

    always_comb begin
        GNT   = '0;
        WINC  = 1'b0;
        WDATA = '0;
        if (WRST_n && write) begin
            GNT[winner] = 1'b1;
            WINC        = 1'b1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (winner == PW'(i)) begin
                    WDATA = DATA[i*DSIZE +: DSIZE];
                end
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          hold;

    // An owner that drops REQ falls back to round robin in the same cycle.
    assign hold   = (state == OWN) && REQ[owner];
    assign found  = hold || rr_found;
    assign winner = hold ? owner : rr_idx;

    always_ff @(posedge WCLK or negedge WRST_n) begin
        if (!WRST_n) begin
            ptr   <= '0;
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
        end else begin
            ptr   <= ptr_next;
            state <= state_next;
            owner <= owner_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        ptr_next   = ptr;
        state_next = state;
        owner_next = owner;
        cnt_next   = cnt;
        if (!WFULL) begin
            if (write && hold) begin
                if (cnt + CW'(1) == CW'(MAX_BURST)) begin
                    ptr_next   = inc_idx(owner);
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CW'(1);
                    state_next = OWN;
                end
            end else if (write) begin
                owner_next = winner;
                if (MAX_BURST == 1) begin
                    ptr_next   = inc_idx(winner);
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = CW'(1);
                    state_next = OWN;
                end
            end else if (state == OWN) begin
                ptr_next   = inc_idx(owner);
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    assign OWNER = (WRST_n && state == OWN) ? owner : '0;
`else
    assign found  = rr_found;
    assign winner = rr_idx;

    always_ff @(posedge WCLK or negedge WRST_n) begin
        if (!WRST_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (write) begin
            ptr_next = inc_idx(winner);
        end
    end

    assign OWNER = '0;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. It shares the FIFO write port (WINC/WDATA/WFULL) among NREQ requesters in the write clock domain. Each cycle it selects at most one requester, forwards that requester's word to the FIFO and acknowledges it. An optional burst mode keeps one owner for up to MAX_BURST consecutive words.

## Interface
- NREQ, 4: number of requesters (2..8)
- DSIZE, 8: data width, equal to the FIFO write data width
- MAX_BURST, 4: maximum consecutive words per ownership (1..15); used only with FIFO_ARB_BURST_EN

- WCLK  in  1  write-domain clock, rising edge
- WRST_n  in  1  asynchronous active-low reset
- REQ  in  NREQ  REQ[i] high = requester i has a valid word on its DATA slice
- DATA  in  NREQ*DSIZE  requester i word at bits [i*DSIZE +: DSIZE]
- WFULL  in  1  FIFO full flag, already in the WCLK domain
- GNT  out  NREQ  one-hot; GNT[i] high = requester i's word is written at this rising edge
- WINC  out  1  FIFO write enable
- WDATA  out  DSIZE  FIFO write data
- OWNER  out  clog2(NREQ)  index of the current burst owner; 0 when there is no owner

## Operation
- Registered state:
  - ptr: round-robin priority pointer, clog2(NREQ) bits
  - state: IDLE or OWN
  - owner: clog2(NREQ) bits
  - cnt: clog2(MAX_BURST+1) bits
- WINC, WDATA and GNT are combinational from this state plus REQ and WFULL. The FIFO write happens on the same edge as the grant.
- Winner selection:
  - IDLE: the winner is the first i with REQ[i]=1, scanning ptr, ptr+1, … modulo NREQ, wrapping from NREQ-1 to 0.
  - OWN with REQ[owner]=1: the winner is owner.
  - OWN with REQ[owner]=0: re-arbitrate exactly as in IDLE in the same cycle. There is no bubble.
- Write condition: a winner exists and WFULL=0. Then:
  - WINC=1
  - WDATA = DATA slice of the winner
  - GNT[winner]=1
  - Otherwise WINC=0, GNT=0 and WDATA=0.
- With WFULL=1, no state changes: ptr, state, owner and cnt all hold. A requester keeps REQ and DATA stable until it sees GNT.
- Without burst: after every write, ptr ← winner+1 mod NREQ and state stays IDLE.
- With burst, after each write:
  - New owner (from IDLE or after re-arbitration): owner ← winner and cnt ← 1. If MAX_BURST=1, release instead.
  - Same owner: cnt ← cnt+1.
  - When cnt reaches MAX_BURST: release, meaning ptr ← owner+1, state ← IDLE, cnt ← 0.
  - Otherwise: state ← OWN.
- If the owner drops REQ with no other requester active: state ← IDLE, ptr ← owner+1, cnt ← 0.

## Timing
- Reset (asynchronous assertion, synchronous-release safe): ptr=0, state=IDLE, owner=0, cnt=0.
- All outputs are 0 while WRST_n is low. GNT, WINC, WDATA and OWNER are 0 from the reset edge.
- Latency from REQ to write is 0 cycles: REQ high with WFULL low gives WINC in the same cycle, written at the next rising edge.
- Throughput is one word per WCLK cycle while WFULL=0.
- WFULL is sampled combinationally. A write is never issued while WFULL=1.
- Simultaneous events:
  - Owner drops REQ on the same cycle another requester raises REQ: the other requester is granted that cycle.
  - All requesters active, no burst: grants rotate 0,1,2,3,0,…
- Reset mid-burst aborts ownership. No GNT is asserted during reset.

## Configuration
- FIFO_ARB_BURST_EN defined: the IDLE/OWN machine and MAX_BURST are active, and OWNER reports the owner while in OWN.
- FIFO_ARB_BURST_EN undefined:
  - Single-word round robin only.
  - state, owner and cnt are not implemented.
  - OWNER is tied to 0.
  - MAX_BURST is ignored.

## Test plan
- Reset check: REQ=4'b1111 held during reset → GNT=0, WINC=0, WDATA=0. After release, the first grant is GNT=4'b0001 with WDATA=DATA[7:0].
- Fairness: REQ=4'b1111 for 8 cycles, no burst, WFULL=0 → GNT sequence 0001,0010,0100,1000 repeated, WINC=1 every cycle.
- Full stall: REQ=4'b0110, WFULL=1 for 5 cycles, then 0 → GNT=0 and WINC=0 for 5 cycles, then GNT=4'b0010 first (ptr unchanged).
- Burst, MAX_BURST=4, REQ=4'b0011 constant → GNT[0] for 4 consecutive cycles, then GNT[1] for 4, with OWNER 0 then 1.
- Early release, burst on: requester 2 owns with cnt=2 and drops REQ while REQ[3]=1 → GNT=4'b1000 in that same cycle, no idle cycle.
- Wrap and reset mid-burst:
  - ptr=3 and REQ=4'b1001 → GNT[3], then GNT[0].
  - WRST_n pulsed low during OWN → outputs 0 immediately. After release, the first grant again starts at ptr=0.
